// File: rtl/CellProcessingPkg.sv
// Shared types for the cell processing datapath and its dispatch controller.
// The dispatch controller FSM state type lives here alongside the datapath
// types so that benches and debug logic can decode dbg_state directly.
package CellProcessingPkg;

    typedef logic [7:0] pixel_t;

    // A 3x3 neighbourhood, element 4 is the centre pixel.
    typedef pixel_t [8:0] cellDepth;

    typedef logic [7:0] userInput_t;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MAX  = 3'd3,
        OP_MIN  = 3'd4,
        OP_AVG  = 3'd5
    } opcodes_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // Saturating 32-bit increment used by the optional stall counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cell_dispatch_ctrl_fifo.sv
// cell_result_fifo: first-word-fall-through result buffer between the cell
// processor and the downstream consumer. Depth must be a power of two so the
// pointers wrap for free. Memory is reset so the head reads zero after reset.
module cell_result_fifo
    import CellProcessingPkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type data_t     = pixel_t,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  data_t            data_i,
    input  logic             pop_i,
    output data_t            data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    data_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign do_pop       = pop_i && (count_q != '0);
    assign empty_o      = (count_q == '0);
    assign data_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // Pointer and occupancy next-state; push+pop together leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cell_dispatch_ctrl.sv
// cell_dispatch_ctrl: issues one frame of cell pairs to a fixed-latency cell
// processor and buffers its results in a FWFT FIFO.
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high; ready never depends on valid.
// Credit: in_ready only while in-flight issues plus buffered results are
// below FIFO_DEPTH, so every result has a reserved slot when it arrives.
// Optional macro CELL_DISPATCH_STATS_EN adds stat_stall_in/stat_stall_out.
module cell_dispatch_ctrl
    import CellProcessingPkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  opcodes_t    cfg_opcode,
    input  userInput_t  cfg_user,
    input  logic        in_valid,
    output logic        in_ready,
    input  cellDepth    in_cellA,
    input  cellDepth    in_cellB,
    output cellDepth    cp_cellA,
    output cellDepth    cp_cellB,
    output opcodes_t    cp_opcode,
    output userInput_t  cp_userInput,
    input  pixel_t      cp_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output pixel_t      out_pixel,
    output logic        busy,
    output logic        done,
    output ctrl_state_t dbg_state
`ifdef CELL_DISPATCH_STATS_EN
    ,
    output logic [31:0] stat_stall_in,
    output logic [31:0] stat_stall_out
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    ctrl_state_t      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    cellDepth         cell_a_q, cell_b_q;
    opcodes_t         opcode_q;
    userInput_t       user_q;

    logic             start_accept;
    logic             issue;
    logic             last_cell;
    logic             push;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count, fifo_count_next;
    logic [CNT_W:0]   credit_used;

    assign start_accept = start && (state_q == IDLE);
    assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign in_ready     = (state_q == RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue        = in_valid && in_ready;
    assign last_cell    = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
    // The oldest stage of the valid pipe marks a result on cp_pixel this cycle.
    assign push         = vld_q[LATENCY-1];

    assign cp_cellA     = cell_a_q;
    assign cp_cellB     = cell_b_q;
    assign cp_opcode    = opcode_q;
    assign cp_userInput = user_q;
    assign out_valid    = !fifo_empty;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign dbg_state    = state_q;

    // Frame FSM; drain ends once nothing is in flight or buffered after this edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue && last_cell) state_d = DRAIN;
            DRAIN:   if ((inflight_d == '0) && (fifo_count_next == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Raster position of the next cell to issue; row holds on the final cell.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_accept) begin
            col_d = '0;
            row_d = '0;
        end else if (issue) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q != ROW_W'(IMG_H - 1)) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // In-flight count and the LATENCY-deep issue tracker.
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !push) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && push) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        vld_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
        end
    end

    // Cell processor operands: cells per issue, config held for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_a_q <= '0;
            cell_b_q <= '0;
            opcode_q <= OP_PASS;
            user_q   <= '0;
        end else begin
            if (start_accept) begin
                opcode_q <= cfg_opcode;
                user_q   <= cfg_user;
            end
            if (issue) begin
                cell_a_q <= in_cellA;
                cell_b_q <= in_cellB;
            end
        end
    end

    cell_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .data_t     (pixel_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .data_i       (cp_pixel),
        .pop_i        (out_ready),
        .data_o       (out_pixel),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next)
    );

`ifdef CELL_DISPATCH_STATS_EN
    logic [31:0] stall_in_q, stall_out_q;

    assign stat_stall_in  = stall_in_q;
    assign stat_stall_out = stall_out_q;

    // Saturating stall counters, restarted with each accepted frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else if (start_accept) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            if ((state_q == RUN) && in_valid && !in_ready) begin
                stall_in_q <= sat_inc32(stall_in_q);
            end
            if (out_valid && !out_ready) begin
                stall_out_q <= sat_inc32(stall_out_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cell_dispatch_ctrl.sv
// Bench for cell_dispatch_ctrl with a small 4x2 frame. A stub cell processor
// with LATENCY-1 register stages feeds cp_pixel. The reference model tracks
// outstanding results as a queue of (value, cycle it becomes visible).
module tb_cell_dispatch_ctrl;
    import CellProcessingPkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int N     = W * H;

    logic        clk;
    logic        rst;
    logic        start;
    opcodes_t    cfg_opcode;
    userInput_t  cfg_user;
    logic        in_valid;
    logic        in_ready;
    cellDepth    in_cellA, in_cellB;
    cellDepth    cp_cellA, cp_cellB;
    opcodes_t    cp_opcode;
    userInput_t  cp_userInput;
    pixel_t      cp_pixel;
    logic        out_valid;
    logic        out_ready;
    pixel_t      out_pixel;
    logic        busy;
    logic        done;
    ctrl_state_t dbg_state;
`ifdef CELL_DISPATCH_STATS_EN
    logic [31:0] stat_stall_in, stat_stall_out;
`endif

    cell_dispatch_ctrl #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_opcode   (cfg_opcode),
        .cfg_user     (cfg_user),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cellA     (in_cellA),
        .in_cellB     (in_cellB),
        .cp_cellA     (cp_cellA),
        .cp_cellB     (cp_cellB),
        .cp_opcode    (cp_opcode),
        .cp_userInput (cp_userInput),
        .cp_pixel     (cp_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
`ifdef CELL_DISPATCH_STATS_EN
        ,
        .stat_stall_in  (stat_stall_in),
        .stat_stall_out (stat_stall_out)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stub cell processor ----------------
    function automatic pixel_t cp_func(input cellDepth a, input cellDepth b,
                                       input opcodes_t op, input userInput_t u);
        pixel_t s;
        s = a[4] + b[0];
        return s ^ u ^ pixel_t'(op);
    endfunction

    pixel_t cpp [LAT-1];
    always @(posedge clk) begin
        cpp[0] <= cp_func(cp_cellA, cp_cellB, cp_opcode, cp_userInput);
        for (int i = 1; i < LAT - 1; i++) begin
            cpp[i] <= cpp[i-1];
        end
    end
    assign cp_pixel = cpp[LAT-2];

    // ---------------- scoreboard / model state ----------------
    int         checks;
    int         failures;
    int         cyc;
    bit         m_active;
    bit         m_done_pend;
    int         m_issued;
    int         m_outstanding;
    int         m_nout;
    opcodes_t   m_op;
    userInput_t m_user;
    cellDepth   m_last_a;
    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         first_issue_cyc;
    int         first_ov_cyc;
    int         last_pop_cyc;
    int         done_cyc;
    bit         got_done;
    int         dut_iss_cnt;

    function automatic cellDepth rand_cell();
        cellDepth c;
        for (int i = 0; i < 9; i++) begin
            c[i] = pixel_t'($urandom);
        end
        return c;
    endfunction

    function automatic void model_clear();
        m_active      = 1'b0;
        m_done_pend   = 1'b0;
        m_issued      = 0;
        m_outstanding = 0;
        m_nout        = 0;
        m_op          = OP_PASS;
        m_user        = '0;
        m_last_a      = '0;
        exp_q.delete();
        exp_t.delete();
    endfunction

    // ---------------- driver: one cycle with model update ----------------
    task automatic step(input bit iv, input bit ordy, input bit st,
                        input opcodes_t op, input userInput_t us);
        bit e_ready;
        bit e_ov;
        bit iss;
        bit pp;
        @(negedge clk);
        in_valid   = iv;
        out_ready  = ordy;
        start      = st;
        cfg_opcode = op;
        cfg_user   = us;
        in_cellA   = rand_cell();
        in_cellB   = rand_cell();
        #1;
        e_ready = m_active && (m_issued < N) && (m_outstanding < DEPTH);
        e_ov    = (exp_q.size() > 0) && (exp_t[0] <= cyc);

        checks += 5;
        if (in_ready !== e_ready) begin
            failures++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ready);
        end
        if (out_valid !== e_ov) begin
            failures++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov);
        end
        if (done !== m_done_pend) begin
            failures++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, m_done_pend);
        end
        if (busy !== m_active) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_active);
        end
        if (cp_cellA !== m_last_a) begin
            failures++;
            $display("FAIL cp_cellA cyc=%0d got=%0h exp=%0h", cyc, cp_cellA, m_last_a);
        end
        if (e_ov) begin
            checks++;
            if (out_pixel !== exp_q[0]) begin
                failures++;
                $display("FAIL out_pixel cyc=%0d got=%0h exp=%0h", cyc, out_pixel, exp_q[0]);
            end
        end
        if (m_active) begin
            checks += 2;
            if (cp_opcode !== m_op) begin
                failures++;
                $display("FAIL cp_opcode cyc=%0d got=%0d exp=%0d", cyc, cp_opcode, m_op);
            end
            if (cp_userInput !== m_user) begin
                failures++;
                $display("FAIL cp_userInput cyc=%0d got=%0h exp=%0h", cyc, cp_userInput, m_user);
            end
        end

        if (done === 1'b1) begin
            got_done = 1'b1;
            done_cyc = cyc;
        end
        if ((out_valid === 1'b1) && (first_ov_cyc < 0)) begin
            first_ov_cyc = cyc;
        end
        if (iv && (in_ready === 1'b1)) begin
            dut_iss_cnt++;
        end

        // model update for the edge that closes this cycle
        iss = iv && e_ready;
        pp  = ordy && e_ov;
        if (st && !m_active && !m_done_pend) begin
            m_active     = 1'b1;
            m_issued     = 0;
            m_nout       = 0;
            m_op         = op;
            m_user       = us;
            first_ov_cyc = -1;
            got_done     = 1'b0;
            dut_iss_cnt  = 0;
        end
        m_done_pend = 1'b0;
        if (iss) begin
            if (m_issued == 0) begin
                first_issue_cyc = cyc;
            end
            exp_q.push_back(cp_func(in_cellA, in_cellB, m_op, m_user));
            exp_t.push_back(cyc + LAT + 1);
            m_issued++;
            m_outstanding++;
            m_last_a = in_cellA;
        end
        if (pp) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            m_outstanding--;
            m_nout++;
            last_pop_cyc = cyc;
        end
        if (m_active && (m_issued == N) && (m_outstanding == 0)) begin
            m_active    = 1'b0;
            m_done_pend = 1'b1;
        end
        cyc++;
    endtask

    task automatic run_until_done(input int budget, input int iv_pct, input int or_pct);
        for (int i = 0; i < budget && !got_done; i++) begin
            step(($urandom_range(99, 0) < iv_pct), ($urandom_range(99, 0) < or_pct),
                 1'b0, OP_PASS, 8'h00);
        end
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL frame_timeout got=no_done exp=done within %0d cycles", budget);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        got_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 8;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if (out_pixel !== 8'h00) begin failures++; $display("FAIL rst_out_pixel got=%0h exp=0", out_pixel); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        if (cp_cellA !== '0) begin failures++; $display("FAIL rst_cp_cellA got=%0h exp=0", cp_cellA); end
        if (cp_opcode !== OP_PASS) begin failures++; $display("FAIL rst_cp_opcode got=%0d exp=0", cp_opcode); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 1'b1, OP_ADD, 8'h5A);
        run_until_done(200, 100, 100);
        checks += 3;
        if (first_ov_cyc - first_issue_cyc != LAT + 1) begin
            failures++;
            $display("FAIL first_latency got=%0d exp=%0d", first_ov_cyc - first_issue_cyc, LAT + 1);
        end
        if (done_cyc - last_pop_cyc != 1) begin
            failures++;
            $display("FAIL done_after_pop got=%0d exp=1", done_cyc - last_pop_cyc);
        end
        if (m_nout != N) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d", m_nout, N);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 1'b0, 1'b1, OP_SUB, 8'h11);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, OP_PASS, 8'h00);
        end
        checks += 2;
        if (dut_iss_cnt != DEPTH) begin
            failures++;
            $display("FAIL bp_issue_count got=%0d exp=%0d", dut_iss_cnt, DEPTH);
        end
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        run_until_done(200, 100, 100);
        checks++;
        if (m_nout != N) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", m_nout, N);
        end
    endtask

    task automatic test_random();
        int total;
        total = 0;
        for (int f = 0; f < 20; f++) begin
            step(1'b0, ($urandom_range(1, 0) == 1), 1'b1,
                 opcodes_t'($urandom_range(5, 0)), userInput_t'($urandom));
            run_until_done(500, 65, 55);
            total += m_nout;
            checks++;
            if (m_nout != N) begin
                failures++;
                $display("FAIL rand_frame_count frame=%0d got=%0d exp=%0d", f, m_nout, N);
            end
            for (int k = 0; k < $urandom_range(3, 0); k++) begin
                step(1'b0, 1'b1, 1'b0, OP_PASS, 8'h00);
            end
        end
        checks++;
        if (total != 20 * N) begin
            failures++;
            $display("FAIL rand_total got=%0d exp=%0d", total, 20 * N);
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b0, 1'b1, OP_MAX, 8'h33);
        for (int i = 0; i < 10 && m_issued < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, OP_PASS, 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL mid_rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        got_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, OP_PASS, 8'h00);
        end
        checks++;
        if (got_done) begin
            failures++;
            $display("FAIL mid_rst_spurious_done got=1 exp=0");
        end
        step(1'b1, 1'b1, 1'b1, OP_MIN, 8'h77);
        run_until_done(300, 80, 80);
        checks++;
        if (m_nout != N) begin
            failures++;
            $display("FAIL mid_rst_clean_count got=%0d exp=%0d", m_nout, N);
        end
    endtask

    task automatic test_start_during_run();
        opcodes_t op_a;
        opcodes_t op_b;
        op_a = opcodes_t'($urandom_range(5, 0));
        op_b = opcodes_t'((int'(op_a) + 1) % 6);
        step(1'b1, 1'b1, 1'b1, op_a, 8'h42);
        step(1'b1, 1'b1, 1'b0, op_a, 8'h42);
        step(1'b1, 1'b1, 1'b1, op_b, 8'h99);
        step(1'b1, 1'b1, 1'b0, op_b, 8'h99);
        checks++;
        if (cp_opcode !== op_a) begin
            failures++;
            $display("FAIL rerun_opcode got=%0d exp=%0d", cp_opcode, op_a);
        end
        run_until_done(300, 100, 100);
        checks++;
        if (m_nout != N) begin
            failures++;
            $display("FAIL rerun_count got=%0d exp=%0d", m_nout, N);
        end
    endtask

`ifdef CELL_DISPATCH_STATS_EN
    task automatic test_stats();
        step(1'b1, 1'b0, 1'b1, OP_AVG, 8'h01);
        for (int i = 0; i < 20 && first_ov_cyc < 0; i++) begin
            step(1'b1, 1'b0, 1'b0, OP_PASS, 8'h00);
        end
        // the step that first saw out_valid was a stalled cycle; nine more
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, OP_PASS, 8'h00);
        end
        step(1'b1, 1'b1, 1'b0, OP_PASS, 8'h00);
        checks++;
        if (stat_stall_out !== 32'd10) begin
            failures++;
            $display("FAIL stat_stall_out got=%0d exp=10", stat_stall_out);
        end
        run_until_done(300, 100, 100);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        first_issue_cyc = 0;
        first_ov_cyc    = -1;
        last_pop_cyc    = 0;
        done_cyc        = 0;
        got_done        = 1'b0;
        dut_iss_cnt     = 0;
        rst             = 1'b0;
        start           = 1'b0;
        cfg_opcode      = OP_PASS;
        cfg_user        = '0;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        in_cellA        = '0;
        in_cellB        = '0;
        model_clear();

        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_start_during_run();
`ifdef CELL_DISPATCH_STATS_EN
        test_stats();
`endif
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
